// File: rtl/dadda_mac_pkg.sv
// dadda_mac_pkg: shared constants and state encoding for the
// Dadda multiplier dot-product accumulator.
package dadda_mac_pkg;

  localparam int PROD_W      = 8;
  localparam int DEF_MUL_LAT = 5;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/dadda_mac_accum_valid_delay_line.sv
// valid_delay_line: DEPTH-deep valid shift register whose output lines
// up with the multiplier product, cleared asynchronously.
module valid_delay_line
  import dadda_mac_pkg::*;
#(
  parameter int DEPTH = DEF_MUL_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/dadda_mac_accum.sv
// dadda_mac_accum: sums LEN valid multiplier products into a result.
// Define DADDA_MAC_SAT_EN to clamp on overflow instead of wrapping.
module dadda_mac_accum
  import dadda_mac_pkg::*;
#(
  parameter int LEN     = 4,
  parameter int ACC_W   = 12,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              overrun,
  output logic              wrap
);

  localparam int CNT_W = $clog2(LEN) + 1;

  state_t           state_q;
  state_t           state_d;
  logic             pv;
  logic             take;
  logic             last;
  logic             carry;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   sum;

  valid_delay_line #(
    .DEPTH(MUL_LAT)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (op_valid),
    .dout (pv)
  );

  assign take  = (state_q == ACC) && pv;
  assign last  = take && (count_q == CNT_W'(LEN - 1));
  assign sum   = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign carry = sum[ACC_W];

`ifdef DADDA_MAC_SAT_EN
  // once clamped, max + prod keeps carrying, so it stays clamped
  assign acc_nxt = carry ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state_q == ACC) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      wrap    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        acc_q   <= '0;
        count_q <= '0;
        wrap    <= 1'b0;
      end
    end else if (take) begin
      acc_q   <= acc_nxt;
      count_q <= last ? '0 : count_q + 1'b1;
      if (carry) wrap <= 1'b1;
    end
  end

  // a completion never stalls; an unaccepted result wins and the new one drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      acc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) overrun <= 1'b0;
      if (last) begin
        if (!acc_valid || acc_ready) begin
          acc_out   <= acc_nxt;
          acc_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dadda_mac_accum.sv
// tb_dadda_mac_accum: randomized scoreboard bench for dadda_mac_accum
// with a behavioural multiplier and dot-product model.
module tb_dadda_mac_accum;

  localparam int LEN     = 4;
  localparam int ACC_W   = 12;
  localparam int MUL_LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             op_valid;
  logic             acc_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic [7:0]       prod;
  logic [7:0]       pipe [MUL_LAT];
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             busy;
  logic             overrun;
  logic             wrap;
  logic [7:0]       acc_out8;
  logic             acc_valid8;
  logic             busy8;
  logic             overrun8;
  logic             wrap8;

  int errors = 0;
  int checks = 0;
  int exp8   = 0;
  logic [ACC_W-1:0] exp_q [$];

  dadda_mac_accum #(
    .LEN(LEN), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid),
    .prod(prod), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy), .overrun(overrun), .wrap(wrap)
  );

  dadda_mac_accum #(
    .LEN(LEN), .ACC_W(8), .MUL_LAT(MUL_LAT)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid),
    .prod(prod), .acc_out(acc_out8), .acc_valid(acc_valid8),
    .acc_ready(acc_ready), .busy(busy8), .overrun(overrun8), .wrap(wrap8)
  );

  // multiplier stand-in: product appears MUL_LAT edges after operands
  always @(posedge clk) begin
    pipe[0] <= 8'(a) * 8'(b);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign prod = pipe[MUL_LAT-1];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d with nothing expected",
                 acc_out);
      end else begin
        logic [ACC_W-1:0] e;
        e = exp_q.pop_front();
        chk("result", int'(acc_out), int'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] av [LEN], input logic [3:0] bv [LEN],
                     input logic [15:0] mask, input bit rnd,
                     input int restart, input bit push);
    int used;
    int sum;
    used = 0;
    sum  = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int s = 0; s < 64 && used < LEN; s++) begin
      bit v;
      v = rnd ? ($urandom_range(0, 2) != 0) : mask[s % 16];
      start    = (s == restart);
      op_valid = v;
      if (v) begin
        a = av[used];
        b = bv[used];
        sum += int'(av[used]) * int'(bv[used]);
        used++;
      end else begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      cyc();
    end
    op_valid = 1'b0;
    start    = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
`ifdef DADDA_MAC_SAT_EN
    exp8 = (sum > 255) ? 255 : sum;
`else
    exp8 = sum % 256;
`endif
    if (push) exp_q.push_back(ACC_W'(sum));
  endtask

  task automatic wait_valid(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!acc_valid && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      cyc();
      n++;
    end
    if (!acc_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no acc_valid after %0d cycles", n);
    end
  endtask

  logic [3:0] va [LEN];
  logic [3:0] vb [LEN];
  logic [3:0] vf [LEN];
  logic [3:0] v1 [LEN];
  logic [3:0] ra [LEN];
  logic [3:0] rb [LEN];
  int n;
  int m;
  bit bok;

  initial begin
    va = '{4'd4, 4'd2, 4'd15, 4'd1};
    vb = '{4'd3, 4'd5, 4'd15, 4'd1};
    vf = '{4'd15, 4'd15, 4'd15, 4'd15};
    v1 = '{4'd1, 4'd1, 4'd1, 4'd1};
    rst_n = 1'b0;
    start = 1'b0;
    op_valid = 1'b0;
    acc_ready = 1'b0;
    a = 4'd0;
    b = 4'd0;
    repeat (3) cyc();
    chk("rst_acc_out", int'(acc_out), 0);
    chk("rst_acc_valid", int'(acc_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    repeat (MUL_LAT + 2) cyc();

    // contiguous run, latency and single-cycle valid
    acc_ready = 1'b1;
    run(va, vb, 16'hffff, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    chk("latency", n, MUL_LAT);
    chk("busy_during_run", int'(bok), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("sum_contig", int'(acc_out), 248);
    cyc();
    chk("valid_one_cycle", int'(acc_valid), 0);

    // gapped run 1,0,0,1,1,0,1
    run(va, vb, 16'b1011001, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    chk("busy_gaps", int'(bok), 1);
    chk("sum_gaps", int'(acc_out), 248);
    cyc();

    // held result, second run dropped
    acc_ready = 1'b0;
    run(va, vb, 16'hffff, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    run(vf, vf, 16'hffff, 1'b0, -1, 1'b0);
    repeat (MUL_LAT + 1) cyc();
    chk("overrun_hold_out", int'(acc_out), 248);
    chk("overrun_hold_valid", int'(acc_valid), 1);
    chk("overrun_set", int'(overrun), 1);
    acc_ready = 1'b1;
    cyc();
    chk("overrun_drain_valid", int'(acc_valid), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // accept on the completion edge: new result replaces old
    acc_ready = 1'b0;
    run(va, vb, 16'hffff, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    run(vf, vf, 16'hffff, 1'b0, -1, 1'b1);
    repeat (MUL_LAT - 1) cyc();
    acc_ready = 1'b1;
    cyc();
    chk("swap_out", int'(acc_out), 900);
    chk("swap_no_overrun", int'(overrun), 0);
    cyc();
    chk("swap_valid_clear", int'(acc_valid), 0);

    // 8-bit instance overflows, 12-bit does not
    run(vf, vf, 16'hffff, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    chk("w8_out", int'(acc_out8), exp8);
    chk("w8_valid", int'(acc_valid8), 1);
    chk("w8_wrap", int'(wrap8), 1);
    chk("w8_overrun", int'(overrun8), 0);
    chk("w8_busy", int'(busy8), 0);
    chk("w12_nowrap", int'(wrap), 0);
    cyc();

    // reset in the middle of a run
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < LEN; k++) begin
      op_valid = 1'b1;
      a = 4'd15;
      b = 4'd15;
      cyc();
    end
    op_valid = 1'b0;
    repeat (MUL_LAT - 2) cyc();
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out", int'(acc_out), 0);
    chk("mid_rst_out8", int'(acc_out8), 0);
    chk("mid_rst_valid", int'(acc_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wrap8", int'(wrap8), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run(v1, v1, 16'hffff, 1'b0, -1, 1'b1);
    wait_valid(n, bok);
    chk("post_rst_sum", int'(acc_out), 4);
    cyc();

    // op_valid while idle is ignored
    for (int k = 0; k < LEN; k++) begin
      op_valid = 1'b1;
      a = 4'($urandom);
      b = 4'($urandom);
      cyc();
    end
    op_valid = 1'b0;
    repeat (MUL_LAT + 3) cyc();
    chk("idle_no_valid", int'(acc_valid), 0);
    chk("idle_out_held", int'(acc_out), 4);
    chk("idle_busy", int'(busy), 0);

    // start during ACC is ignored
    run(va, vb, 16'hffff, 1'b0, 1, 1'b1);
    wait_valid(n, bok);
    chk("restart_ignored", int'(acc_out), 248);
    cyc();

    // randomized runs with random gaps and back-pressure
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < LEN; k++) begin
        ra[k] = 4'($urandom);
        rb[k] = 4'($urandom);
      end
      run(ra, rb, 16'h0, 1'b1, -1, 1'b1);
      m = 0;
      while (exp_q.size() != 0 && m < 100) begin
        acc_ready = 1'($urandom_range(0, 1));
        cyc();
        m++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: run %0d pending %0d", r, exp_q.size());
        exp_q.delete();
      end
      acc_ready = 1'b1;
      cyc();
    end

    repeat (10) cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dadda_mac_accum.md
Name: dadda_mac_accum

Overview:
- Downstream consumer of the 4-bit pipelined Dadda multiplier.
- Tracks the validity of operands issued into the multiplier with a delay line matched to its latency.
- Accumulates LEN consecutive valid 8-bit products into a dot-product result.
- Presents the result on a valid/ready output handshake; the multiplier cannot stall, so this block never back-pressures it.

Parameters:
- LEN, 4: number of valid products per accumulation (2..16).
- ACC_W, 12: accumulator/result width; 12 holds 16*255 without wrap.
- MUL_LAT, 5: clock edges from operands applied to the multiplier to the matching product on prod.

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new accumulation.
- op_valid  in  1  high in the same cycle valid A/B are applied to the multiplier.
- prod  in  8  multiplier product output.
- acc_out  out  ACC_W  accumulated result.
- acc_valid  out  1  acc_out holds an unconsumed result.
- acc_ready  in  1  downstream accepts the result.
- busy  out  1  high while in state ACC.
- overrun  out  1  sticky; a result completed while the previous one was still unaccepted.
- wrap  out  1  sticky; the accumulator exceeded 2^ACC_W-1 during the current run.

Behaviour:
- Reset is asynchronous, active-low. Reset values: acc_out=0, acc_valid=0, busy=0, overrun=0, wrap=0, state=IDLE, count=0, delay line all 0.
- Reset mid-run discards in-flight products and any pending result.
- Delay line:
  - pv = op_valid delayed by MUL_LAT clocks.
  - Shifts every cycle regardless of state.
  - pv high marks prod as valid in that cycle.
- FSM states: IDLE, ACC.
- IDLE:
  - pv is ignored.
  - start moves to ACC next cycle; on the same edge acc=0, count=0, overrun=0, wrap=0.
- ACC:
  - busy=1.
  - Each cycle with pv=1: acc += zero-extended prod and count++.
  - On the pv cycle where count==LEN-1, the final sum (including that product) is the completed result and the FSM returns to IDLE.
  - start in ACC is ignored.
- Result register:
  - On completion with acc_valid=0, or with acc_valid=1 and acc_ready=1 in the same cycle: acc_out<=final sum, acc_valid<=1.
  - On completion with acc_valid=1 and acc_ready=0: acc_out is kept unchanged, the new sum is dropped, overrun<=1.
  - acc_valid=1 and acc_ready=1 with no completion: acc_valid<=0 next cycle; acc_out is held.
  - acc_out is stable while acc_valid=1 and acc_ready=0.
- Latency:
  - The last product is accumulated on the edge at which its pv is high.
  - acc_valid rises on that same edge, i.e. MUL_LAT edges after its op_valid.
- Width: the adder is ACC_W+1 bits. A carry out of bit ACC_W-1 sets wrap; behaviour on that carry depends on SAT_EN (see Optional Feature).
- pv gaps in ACC are allowed: the count only advances on pv=1.
- start with pv=1 in the same cycle: that product is not counted.

Optional Feature:
- Macro: DADDA_MAC_SAT_EN.
- Defined: on a carry out, acc clamps to 2^ACC_W-1 and stays there for the rest of the run; wrap is still set.
- Undefined: acc wraps modulo 2^ACC_W; wrap is set.

Decomposition:
- Shared package dadda_mac_pkg:
  - PROD_W=8.
  - Default MUL_LAT=5.
  - State encoding IDLE=1'b0, ACC=1'b1.
- One sub-module: valid_delay_line, a MUL_LAT-deep shift register with async active-low clear.
- The FSM, accumulator and result register stay in the top level.

Test Plan:
- Vector pairs (4,3),(2,5),(15,15),(1,1) with LEN=4, start then op_valid on 4 consecutive cycles, acc_ready=1 -> acc_out=248, acc_valid high for exactly one cycle, MUL_LAT edges after the last op_valid.
- Same vectors with op_valid gaps (pattern 1,0,0,1,1,0,1) -> acc_out=248; busy stays high until the 4th valid product.
- First result held with acc_ready=0, then a second run (all 15x15, expected 900) completes -> acc_out stays 248, overrun=1; raising acc_ready then clears acc_valid. Repeat with acc_ready=1 on the completion cycle -> acc_out=900, overrun=0.
- ACC_W=8, four 15x15 products:
  - Without DADDA_MAC_SAT_EN -> acc_out=900 mod 256=132, wrap=1.
  - With DADDA_MAC_SAT_EN -> acc_out=255, wrap=1.
- rst_n pulsed low after 2 of 4 products -> all outputs 0 immediately; a following complete run with (1,1)x4 -> acc_out=4 with no stale contribution.
- op_valid pulses while IDLE with no start -> acc_valid stays 0, acc_out unchanged; start asserted during ACC -> count is not reset and the result is unaffected.
